// File: rtl/sc_spi_pkg.sv
// rtl/sc_spi_pkg.sv - shared constants, FSM encodings and frame-width helper for the SPI transfer sequencer
package sc_spi_pkg;

    localparam int NWORD = 16;
    localparam int AW    = 4;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_START = 3'd1;
    localparam logic [2:0] ST_WBSY  = 3'd2;
    localparam logic [2:0] ST_RUN   = 3'd3;
    localparam logic [2:0] ST_NEXT  = 3'd4;

    // Number of 32-bit words one frame occupies, 1..16, from the upper DWIDTH bits.
    function automatic logic [4:0] fw(input logic [3:0] dwidth_hi);
        return {1'b0, dwidth_hi} + 5'd1;
    endfunction

endpackage

// File: rtl/sc_spi_wbuf.sv
// rtl/sc_spi_wbuf.sv - NWORD x 32 register file, one write port, one asynchronous read port
//
// Ports:
//   SPICLK      write clock
//   we/waddr/wdata   write strobe, address, data (written on the clock edge)
//   raddr/rdata      asynchronous read address and data
// Contents are not reset.
module sc_spi_wbuf
    import sc_spi_pkg::*;
(
    input  logic          SPICLK,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [31:0]   wdata,
    input  logic [AW-1:0] raddr,
    output logic [31:0]   rdata
);

    logic [31:0] mem [NWORD];

    always_ff @(posedge SPICLK) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/sc_spi_xfer_seq.sv
// rtl/sc_spi_xfer_seq.sv - transfer sequencer feeding the SPI protocol engine: TX/RX word buffers and frame sequencing
//
// Ports:
//   SPICLK, SYSRSTB            clock, asynchronous active-low reset
//   TXWE/TXWADDR/TXWDATA       TX buffer write port (accepted at any time)
//   RXRADDR/RXRDATA            RX buffer read port, one-cycle latency
//   GO/ABORT/NFRAME/KEEPCS     sequence control from the register block
//   DWIDTH                     frame width minus 1, as given to the engine
//   BUSY/DONE/RXCNT/RXOVF      sequence status
//   SPISTART/SPIBUSY/CSEXTEND  engine handshake and chip-select extension
//   TXDPT/TXDATA               engine word pointer and the word served for it
//   RXDATA/RXVALID             engine received word, valid flagged by a toggle
module sc_spi_xfer_seq
    import sc_spi_pkg::*;
(
    input  logic        SPICLK,
    input  logic        SYSRSTB,
    input  logic        TXWE,
    input  logic [3:0]  TXWADDR,
    input  logic [31:0] TXWDATA,
    input  logic [3:0]  RXRADDR,
    output logic [31:0] RXRDATA,
    input  logic        GO,
    input  logic        ABORT,
    input  logic [4:0]  NFRAME,
    input  logic        KEEPCS,
    input  logic [8:0]  DWIDTH,
    output logic        BUSY,
    output logic        DONE,
    output logic [4:0]  RXCNT,
    output logic        RXOVF,
    output logic        SPISTART,
    input  logic        SPIBUSY,
    output logic        CSEXTEND,
    input  logic [3:0]  TXDPT,
    output logic [31:0] TXDATA,
    input  logic [31:0] RXDATA,
    input  logic        RXVALID
);

    logic [2:0]    state;
    logic [4:0]    rem;
    logic [4:0]    rem_dec;
    logic          keepcs;
    logic          abort_pend;
    logic          abort_now;
    logic [AW-1:0] base;
    logic [AW-1:0] rxwp;
    logic [AW-1:0] tx_raddr;
    logic [AW-1:0] rx_waddr;
    logic [4:0]    fw_w;
    logic          rxv_d;
    logic          rx_tgl;
    logic          go_acc;
    logic [31:0]   rx_rd;
    logic          dwidth_unused;

    // Only the word-count bits of the frame width matter here.
    assign dwidth_unused = ^DWIDTH[4:0];
    assign fw_w          = fw(DWIDTH[8:5]);

    assign go_acc    = GO && (state == ST_IDLE);
    assign rx_tgl    = RXVALID ^ rxv_d;
    assign rem_dec   = rem - 5'd1;
    assign abort_now = abort_pend | ABORT;
    assign SPISTART  = (state == ST_START);

    // The engine samples TXDATA in the same cycle it moves TXDPT, so the
    // TX read path stays combinational.
    assign tx_raddr = base + TXDPT;

    // A toggle landing on the GO edge belongs to the new sequence: slot 0.
    assign rx_waddr = go_acc ? '0 : rxwp;

    sc_spi_wbuf u_txbuf (
        .SPICLK (SPICLK),
        .we     (TXWE),
        .waddr  (TXWADDR),
        .wdata  (TXWDATA),
        .raddr  (tx_raddr),
        .rdata  (TXDATA)
    );

    sc_spi_wbuf u_rxbuf (
        .SPICLK (SPICLK),
        .we     (rx_tgl),
        .waddr  (rx_waddr),
        .wdata  (RXDATA),
        .raddr  (RXRADDR),
        .rdata  (rx_rd)
    );

    // RX capture runs in every state; the slot is written even once the
    // count has saturated, which is what flags the overflow.
    always_ff @(posedge SPICLK or negedge SYSRSTB) begin
        if (!SYSRSTB) begin
            rxv_d   <= 1'b0;
            rxwp    <= '0;
            RXCNT   <= 5'd0;
            RXOVF   <= 1'b0;
            RXRDATA <= 32'd0;
        end else begin
            rxv_d   <= RXVALID;
            RXRDATA <= rx_rd;
            if (go_acc) begin
                rxwp  <= {{(AW-1){1'b0}}, rx_tgl};
                RXCNT <= {4'd0, rx_tgl};
                RXOVF <= 1'b0;
            end else if (rx_tgl) begin
                rxwp <= rxwp + 4'd1;
                if (RXCNT == 5'(NWORD)) begin
                    RXOVF <= 1'b1;
                end else begin
                    RXCNT <= RXCNT + 5'd1;
                end
            end
        end
    end

    always_ff @(posedge SPICLK or negedge SYSRSTB) begin
        if (!SYSRSTB) begin
            state      <= ST_IDLE;
            rem        <= 5'd0;
            keepcs     <= 1'b0;
            abort_pend <= 1'b0;
            base       <= '0;
            BUSY       <= 1'b0;
            DONE       <= 1'b0;
            CSEXTEND   <= 1'b0;
        end else begin
            DONE <= 1'b0;

            // Outside IDLE an abort cannot stop the running frame; it only
            // drops CS extension and prevents the next start.
            if (ABORT && (state != ST_IDLE)) begin
                abort_pend <= 1'b1;
                CSEXTEND   <= 1'b0;
            end

            case (state)
                ST_IDLE: begin
                    if (GO) begin
                        base       <= '0;
                        keepcs     <= KEEPCS;
                        abort_pend <= 1'b0;
                        CSEXTEND   <= KEEPCS | (NFRAME > 5'd1);
                        if (NFRAME == 5'd0) begin
                            DONE <= 1'b1;
                        end else begin
                            rem   <= NFRAME;
                            BUSY  <= 1'b1;
                            state <= ST_START;
                        end
                    end else if (ABORT) begin
                        CSEXTEND <= 1'b0;
                    end
                end
                ST_START: begin
                    state <= ST_WBSY;
                end
                ST_WBSY: begin
                    if (SPIBUSY) begin
                        state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (!SPIBUSY) begin
                        state <= ST_NEXT;
                    end
                end
                ST_NEXT: begin
                    rem  <= rem_dec;
                    base <= base + fw_w[AW-1:0];
                    if ((rem_dec != 5'd0) && !abort_now) begin
                        state    <= ST_START;
                        // Entering the last frame hands CS over to keepcs.
                        CSEXTEND <= (rem_dec > 5'd1) | keepcs;
                    end else begin
                        state      <= ST_IDLE;
                        DONE       <= 1'b1;
                        BUSY       <= 1'b0;
                        abort_pend <= 1'b0;
                        CSEXTEND   <= abort_now ? 1'b0 : keepcs;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sc_spi_xfer_seq.sv
// tb/tb_sc_spi_xfer_seq.sv - self-checking bench for sc_spi_xfer_seq with an inline engine model and RX scoreboard
module tb_sc_spi_xfer_seq;

    logic        SPICLK = 1'b0;
    logic        SYSRSTB;
    logic        TXWE;
    logic [3:0]  TXWADDR;
    logic [31:0] TXWDATA;
    logic [3:0]  RXRADDR;
    logic [31:0] RXRDATA;
    logic        GO;
    logic        ABORT;
    logic [4:0]  NFRAME;
    logic        KEEPCS;
    logic [8:0]  DWIDTH;
    logic        BUSY;
    logic        DONE;
    logic [4:0]  RXCNT;
    logic        RXOVF;
    logic        SPISTART;
    logic        SPIBUSY;
    logic        CSEXTEND;
    logic [3:0]  TXDPT;
    logic [31:0] TXDATA;
    logic [31:0] RXDATA;
    logic        RXVALID;

    always #5 SPICLK = ~SPICLK;

    sc_spi_xfer_seq dut (
        .SPICLK   (SPICLK),
        .SYSRSTB  (SYSRSTB),
        .TXWE     (TXWE),
        .TXWADDR  (TXWADDR),
        .TXWDATA  (TXWDATA),
        .RXRADDR  (RXRADDR),
        .RXRDATA  (RXRDATA),
        .GO       (GO),
        .ABORT    (ABORT),
        .NFRAME   (NFRAME),
        .KEEPCS   (KEEPCS),
        .DWIDTH   (DWIDTH),
        .BUSY     (BUSY),
        .DONE     (DONE),
        .RXCNT    (RXCNT),
        .RXOVF    (RXOVF),
        .SPISTART (SPISTART),
        .SPIBUSY  (SPIBUSY),
        .CSEXTEND (CSEXTEND),
        .TXDPT    (TXDPT),
        .TXDATA   (TXDATA),
        .RXDATA   (RXDATA),
        .RXVALID  (RXVALID)
    );

    typedef struct {
        logic [3:0]  addr;
        logic [31:0] data;
    } rxexp_t;

    int          n_chk  = 0;
    int          n_pass = 0;
    logic [31:0] tx_model [16];
    rxexp_t      sb [$];
    int          m_cnt;
    logic [3:0]  m_wp;
    logic        m_ovf;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(negedge SPICLK);
    endtask

    task automatic wr_tx(input int a, input logic [31:0] d);
        TXWADDR = a[3:0];
        TXWDATA = d;
        TXWE    = 1'b1;
        cyc();
        TXWE    = 1'b0;
        tx_model[a] = d;
    endtask

    // Engine delivers one word: toggle RXVALID and record the expected slot.
    task automatic rx_word();
        RXDATA  = $urandom;
        RXVALID = ~RXVALID;
        sb.push_back('{addr: m_wp, data: RXDATA});
        m_wp = m_wp + 4'd1;
        if (m_cnt == 16) m_ovf = 1'b1;
        else m_cnt++;
    endtask

    task automatic check_rx();
        logic [31:0] e [16];
        bit          v [16];
        rxexp_t      x;
        for (int i = 0; i < 16; i++) v[i] = 1'b0;
        check_val("rxcnt", RXCNT, m_cnt);
        check_val("rxovf", RXOVF, m_ovf);
        while (sb.size() > 0) begin
            x = sb.pop_front();
            e[x.addr] = x.data;
            v[x.addr] = 1'b1;
        end
        for (int i = 0; i < 16; i++) begin
            if (v[i]) begin
                RXRADDR = i[3:0];
                cyc();
                check_val($sformatf("rxbuf%0d", i), RXRDATA, e[i]);
            end
        end
    endtask

    task automatic run_seq(input int nf, input int dw, input bit kcs, input int ab_fr);
        int fwv;
        int base;
        int starts;
        int extra;
        bit aborted;
        fwv     = dw / 32 + 1;
        base    = 0;
        starts  = 0;
        extra   = 0;
        aborted = 1'b0;
        NFRAME  = nf[4:0];
        DWIDTH  = dw[8:0];
        KEEPCS  = kcs;
        m_cnt   = 0;
        m_wp    = 4'd0;
        m_ovf   = 1'b0;
        GO      = 1'b1;
        cyc();
        GO      = 1'b0;
        if (nf == 0) begin
            check_val("nf0_done", DONE, 1);
            check_val("nf0_start", SPISTART, 0);
            check_val("nf0_busy", BUSY, 0);
            cyc();
            check_val("nf0_done_1cyc", DONE, 0);
            check_val("nf0_no_start", SPISTART, 0);
            return;
        end
        check_val("go_busy", BUSY, 1);
        for (int f = 0; f < nf && !aborted; f++) begin
            check_val($sformatf("start_f%0d", f), SPISTART, 1);
            check_val($sformatf("cs_f%0d", f), CSEXTEND, ((nf - f) > 1) ? 1 : kcs);
            SPIBUSY = 1'b1;
            cyc();
            check_val("start_1cyc", SPISTART, 0);
            for (int w = 0; w < fwv; w++) begin
                TXDPT = w[3:0];
                #1;
                check_val($sformatf("txdata_f%0d_w%0d", f, w), TXDATA, tx_model[(base + w) % 16]);
                rx_word();
                if (f == 0 && w == 0) GO = 1'b1;
                if (f + 1 == ab_fr && w == 0) ABORT = 1'b1;
                cyc();
                GO = 1'b0;
                if (ABORT) begin
                    ABORT   = 1'b0;
                    aborted = 1'b1;
                    check_val("abort_cs", CSEXTEND, 0);
                end
            end
            SPIBUSY = 1'b0;
            TXDPT   = 4'd0;
            base    = (base + fwv) % 16;
            starts++;
            cyc();
            check_val("gap_start", SPISTART, 0);
            check_val("gap_done", DONE, 0);
            cyc();
        end
        check_val("done", DONE, 1);
        check_val("done_busy", BUSY, 0);
        check_val("done_cs", CSEXTEND, aborted ? 0 : kcs);
        check_val("starts", starts, (ab_fr != 0) ? ab_fr : nf);
        for (int i = 0; i < 4; i++) begin
            cyc();
            if (SPISTART || DONE) extra++;
        end
        check_val("no_extra", extra, 0);
        check_rx();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish");
        $fatal(1);
    end

    initial begin
        int bad;
        SYSRSTB = 1'b0;
        TXWE    = 1'b0;
        TXWADDR = 4'd0;
        TXWDATA = 32'd0;
        RXRADDR = 4'd0;
        GO      = 1'b0;
        ABORT   = 1'b0;
        NFRAME  = 5'd0;
        KEEPCS  = 1'b0;
        DWIDTH  = 9'd31;
        SPIBUSY = 1'b0;
        TXDPT   = 4'd0;
        RXDATA  = 32'd0;
        RXVALID = 1'b0;
        repeat (3) cyc();
        check_val("rst_busy", BUSY, 0);
        check_val("rst_done", DONE, 0);
        check_val("rst_start", SPISTART, 0);
        check_val("rst_cs", CSEXTEND, 0);
        check_val("rst_rxcnt", RXCNT, 0);
        check_val("rst_rxovf", RXOVF, 0);
        check_val("rst_rxrdata", RXRDATA, 0);
        SYSRSTB = 1'b1;
        cyc();

        for (int i = 0; i < 16; i++) wr_tx(i, $urandom);
        wr_tx(0, 32'hA5A5_0001);

        run_seq(1, 31, 1'b0, 0);
        run_seq(3, 63, 1'b0, 0);
        run_seq(16, 63, 1'b0, 0);
        run_seq(5, 31, 1'b0, 2);

        run_seq(1, 31, 1'b1, 0);
        repeat (3) cyc();
        check_val("keepcs_hold", CSEXTEND, 1);
        run_seq(1, 31, 1'b0, 0);
        repeat (2) cyc();
        check_val("keepcs_released", CSEXTEND, 0);

        run_seq(1, 31, 1'b1, 0);
        ABORT = 1'b1;
        cyc();
        ABORT = 1'b0;
        check_val("idle_abort_cs", CSEXTEND, 0);
        check_val("idle_abort_busy", BUSY, 0);

        NFRAME = 5'd2;
        DWIDTH = 9'd31;
        KEEPCS = 1'b1;
        m_cnt  = 0;
        m_wp   = 4'd0;
        m_ovf  = 1'b0;
        GO     = 1'b1;
        cyc();
        GO     = 1'b0;
        check_val("rstrun_start", SPISTART, 1);
        SPIBUSY = 1'b1;
        cyc();
        cyc();
        rx_word();
        cyc();
        check_val("rstrun_rxcnt", RXCNT, 1);
        check_val("rstrun_cs", CSEXTEND, 1);
        SYSRSTB = 1'b0;
        RXVALID = 1'b0;
        #1;
        check_val("rstrun_busy0", BUSY, 0);
        check_val("rstrun_start0", SPISTART, 0);
        check_val("rstrun_cs0", CSEXTEND, 0);
        check_val("rstrun_rxcnt0", RXCNT, 0);
        cyc();
        SYSRSTB = 1'b1;
        SPIBUSY = 1'b0;
        bad = 0;
        for (int i = 0; i < 4; i++) begin
            cyc();
            if (DONE || SPISTART || BUSY) bad++;
        end
        check_val("rstrun_quiet", bad, 0);
        sb.delete();
        run_seq(0, 31, 1'b0, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
